// File: rtl/store_w_beat_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_w_beat_gen_if
//  Description : AXI W-channel bundle between the store beat generator and
//                the AXI write-data port. Signal names are kept from the
//                generator's point of view (_o driven by it, _i seen by it).
//  Ports       : master - beat generator side (drives valid/payload)
//                slave  - AXI port side (drives ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_w_beat_gen_if #(
   parameter int unsigned AxiDataWidth = 128,
   parameter int unsigned AxiUserWidth = 1
);
   localparam int unsigned B = AxiDataWidth / 8;

   logic                    axi_w_valid_o;
   logic                    axi_w_ready_i;
   logic [AxiDataWidth-1:0] w_data_o;
   logic [B-1:0]            w_strb_o;
   logic                    w_last_o;
   logic [AxiUserWidth-1:0] w_user_o;

   modport master (
      output axi_w_valid_o,
      input  axi_w_ready_i,
      output w_data_o,
      output w_strb_o,
      output w_last_o,
      output w_user_o
   );

   modport slave (
      input  axi_w_valid_o,
      output axi_w_ready_i,
      input  w_data_o,
      input  w_strb_o,
      input  w_last_o,
      input  w_user_o
   );
endinterface
`default_nettype wire

// File: rtl/store_w_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : store_w_beat_gen_fifo
//  Description : Registered circular FIFO. A pushed entry becomes visible at
//                the head one cycle after the push. The caller guards push
//                against full and pop against empty using count_o.
//  Ports       : clk_i, rst_ni        - clock, async active-low reset
//                push_i / data_i      - write strobe and entry
//                pop_i / data_o       - read strobe and head entry
//                count_o              - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module store_w_beat_gen_fifo #(
   parameter  int unsigned Depth = 4,
   parameter  int unsigned Width = 8,
   localparam int unsigned PtrW  = $clog2(Depth),
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   input  wire logic             push_i,
   input  wire logic [Width-1:0] data_i,
   input  wire logic             pop_i,
   output logic      [Width-1:0] data_o,
   output logic      [CntW-1:0]  count_o
);
   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q;
   logic [PtrW-1:0]  rptr_q;
   logic [CntW-1:0]  count_q;

   // Explicit wrap so non power-of-two depths work.
   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wrap_inc(wptr_q);
         if (pop_i)  rptr_q <= wrap_inc(rptr_q);
         if (push_i && !pop_i)      count_q <= count_q + CntW'(1);
         else if (pop_i && !push_i) count_q <= count_q - CntW'(1);
      end
   end

   // Storage needs no reset: the occupancy count qualifies every entry.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wptr_q] <= data_i;
   end

   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;
endmodule

// ============================================================================
//  Module      : store_w_beat_gen
//  Description : AXI W beat generator for the vector store path. Queues burst
//                descriptors and data beats, derives burst-edge strobes,
//                merges the element mask and generates wlast.
//  Ports       : clk_i, rst_ni              - clock, async active-low reset
//                txn_*                      - burst descriptor push (off/len/nbytes)
//                data_*                     - bus-aligned data beat push
//                axi_w (master modport)     - AXI W channel
//                burst_done_o               - pulse the cycle after a wlast beat
//                busy_o                     - work pending or burst active
//  Revision    : 1.0 - initial release
// ============================================================================
module store_w_beat_gen #(
   parameter  int unsigned AxiDataWidth = 128,
   parameter  int unsigned AxiUserWidth = 1,
   parameter  int unsigned TxnDepth     = 4,
   parameter  int unsigned DataDepth    = 4,
   parameter  bit          MaskEn       = 1'b1,
   localparam int unsigned B            = AxiDataWidth / 8,
   localparam int unsigned OffW         = $clog2(B)
) (
   input  wire logic                    clk_i,
   input  wire logic                    rst_ni,
   input  wire logic                    txn_valid_i,
   output logic                         txn_ready_o,
   input  wire logic [OffW-1:0]         txn_off_i,
   input  wire logic [7:0]              txn_len_i,
   input  wire logic [11:0]             txn_nbytes_i,
   input  wire logic                    data_valid_i,
   output logic                         data_ready_o,
   input  wire logic [AxiDataWidth-1:0] data_i,
   input  wire logic [B-1:0]            data_strb_i,
   input  wire logic [AxiUserWidth-1:0] data_user_i,
   store_w_beat_gen_if.master           axi_w,
   output logic                         burst_done_o,
   output logic                         busy_o
);
   localparam int unsigned TxnCntW  = $clog2(TxnDepth + 1);
   localparam int unsigned DataCntW = $clog2(DataDepth + 1);

   // The end offset is folded at push time so the queue holds only what the
   // strobe logic needs.
   typedef struct packed {
      logic [OffW-1:0] off;
      logic [7:0]      len;
      logic [OffW-1:0] endo;
   } txn_t;

   typedef struct packed {
      logic [AxiUserWidth-1:0] user;
      logic [B-1:0]            strb;
      logic [AxiDataWidth-1:0] data;
   } beat_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           beat_q, beat_d;
   logic                 burst_done_q;

   logic [TxnCntW-1:0]   w_txn_cnt;
   logic [DataCntW-1:0]  w_data_cnt;
   logic                 w_txn_push, w_data_push;
   logic                 w_txn_pop, w_data_pop;
   logic                 w_txn_empty, w_data_empty;
   logic [12:0]          w_end_full;
   txn_t                 w_txn_in, w_txn_head;
   beat_t                w_beat_in, w_beat_head;
   logic                 w_first, w_is_last;
   logic [B-1:0]         w_lo_mask, w_hi_mask, w_elem_mask;
   logic                 w_valid, w_hs;

   // ------------------------------------------------------------------ FIFOs
   assign txn_ready_o  = (w_txn_cnt != TxnCntW'(TxnDepth));
   assign data_ready_o = (w_data_cnt != DataCntW'(DataDepth));
   assign w_txn_push   = txn_valid_i & txn_ready_o;
   assign w_data_push  = data_valid_i & data_ready_o;
   assign w_txn_empty  = (w_txn_cnt == '0);
   assign w_data_empty = (w_data_cnt == '0);

   assign w_end_full    = 13'(txn_off_i) + 13'(txn_nbytes_i);
   assign w_txn_in.off  = txn_off_i;
   assign w_txn_in.len  = txn_len_i;
   assign w_txn_in.endo = w_end_full[OffW-1:0];

   assign w_beat_in.user = data_user_i;
   assign w_beat_in.strb = data_strb_i;
   assign w_beat_in.data = data_i;

   store_w_beat_gen_fifo #(
      .Depth (TxnDepth),
      .Width ($bits(txn_t))
   ) u_txn_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_txn_push),
      .data_i  (w_txn_in),
      .pop_i   (w_txn_pop),
      .data_o  (w_txn_head),
      .count_o (w_txn_cnt)
   );

   store_w_beat_gen_fifo #(
      .Depth (DataDepth),
      .Width ($bits(beat_t))
   ) u_data_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_data_push),
      .data_i  (w_beat_in),
      .pop_i   (w_data_pop),
      .data_o  (w_beat_head),
      .count_o (w_data_cnt)
   );

   // ------------------------------------------------------- strobe derivation
   assign w_first   = (beat_q == 8'd0);
   assign w_is_last = (beat_q == w_txn_head.len);

   assign w_lo_mask   = w_first ? ({B{1'b1}} << w_txn_head.off) : {B{1'b1}};
   // endo == 0 means the burst ends exactly on a bus boundary: full last beat.
   assign w_hi_mask   = (w_is_last && (w_txn_head.endo != '0))
                        ? ~({B{1'b1}} << w_txn_head.endo) : {B{1'b1}};
   assign w_elem_mask = MaskEn ? w_beat_head.strb : {B{1'b1}};

   // --------------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         burst_done_q <= w_hs & w_is_last;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      w_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            beat_d = '0;
            // A descriptor being pushed now is at the head next cycle.
            if (!w_txn_empty || w_txn_push) state_d = BURST;
         end
         BURST: begin
            w_valid = !w_data_empty;
            if (w_valid && axi_w.axi_w_ready_i) begin
               if (w_is_last) begin
                  beat_d = '0;
                  // Stay in BURST when a follower exists so bursts chain
                  // without a bubble.
                  if ((w_txn_cnt == TxnCntW'(1)) && !w_txn_push) state_d = IDLE;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign w_hs       = w_valid & axi_w.axi_w_ready_i;
   assign w_data_pop = w_hs;
   assign w_txn_pop  = w_hs & w_is_last;

   // ----------------------------------------------------------------- outputs
   assign axi_w.axi_w_valid_o = w_valid;
   assign axi_w.w_data_o      = w_beat_head.data;
   assign axi_w.w_user_o      = w_beat_head.user;
   assign axi_w.w_strb_o      = w_lo_mask & w_hi_mask & w_elem_mask;
   assign axi_w.w_last_o      = (state_q == BURST) && w_is_last;

   assign burst_done_o = burst_done_q;
   assign busy_o       = !w_txn_empty || !w_data_empty || (state_q != IDLE);

`ifndef SYNTHESIS
   // Upstream must send len consistent with the byte span of the burst.
   always_ff @(posedge clk_i) begin
      if (rst_ni && w_txn_push) begin
         assert ((32'(txn_len_i) + 32'd1) == ((32'(w_end_full) + B - 32'd1) / B))
            else $error("store_w_beat_gen: descriptor len does not match off/nbytes");
      end
   end
`endif
endmodule
`default_nettype wire

// File: tb/tb_store_w_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_w_beat_gen
//  Description : Directed self-checking bench for store_w_beat_gen (B = 16).
//                A second instance with MaskEn = 0 shares every input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_w_beat_gen;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         txn_valid = 1'b0;
   logic [3:0]   txn_off = '0;
   logic [7:0]   txn_len = '0;
   logic [11:0]  txn_nbytes = '0;
   logic         data_valid = 1'b0;
   logic [127:0] data = '0;
   logic [15:0]  strb = '0;
   logic [0:0]   user = '0;
   logic         ready = 1'b0;

   logic txn_ready, data_ready, done, busy;
   logic txn_ready2, data_ready2, done2, busy2;

   int n_assert = 0;
   int n_fail   = 0;

   int           nxt, k;
   logic         acc, hs, have_prev;
   logic [144:0] prev_pay;

   store_w_beat_gen_if #(.AxiDataWidth(128), .AxiUserWidth(1)) w_if ();
   store_w_beat_gen_if #(.AxiDataWidth(128), .AxiUserWidth(1)) w_if2 ();
   assign w_if.axi_w_ready_i  = ready;
   assign w_if2.axi_w_ready_i = ready;

   store_w_beat_gen #(.AxiDataWidth(128), .AxiUserWidth(1), .TxnDepth(4),
                      .DataDepth(4), .MaskEn(1'b1)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .txn_valid_i  (txn_valid),
      .txn_ready_o  (txn_ready),
      .txn_off_i    (txn_off),
      .txn_len_i    (txn_len),
      .txn_nbytes_i (txn_nbytes),
      .data_valid_i (data_valid),
      .data_ready_o (data_ready),
      .data_i       (data),
      .data_strb_i  (strb),
      .data_user_i  (user),
      .axi_w        (w_if),
      .burst_done_o (done),
      .busy_o       (busy)
   );

   store_w_beat_gen #(.AxiDataWidth(128), .AxiUserWidth(1), .TxnDepth(4),
                      .DataDepth(4), .MaskEn(1'b0)) u_dut_nomask (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .txn_valid_i  (txn_valid),
      .txn_ready_o  (txn_ready2),
      .txn_off_i    (txn_off),
      .txn_len_i    (txn_len),
      .txn_nbytes_i (txn_nbytes),
      .data_valid_i (data_valid),
      .data_ready_o (data_ready2),
      .data_i       (data),
      .data_strb_i  (strb),
      .data_user_i  (user),
      .axi_w        (w_if2),
      .burst_done_o (done2),
      .busy_o       (busy2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] pat(input int n);
      return {4{32'hC0DE_0000 ^ 32'(n)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [144:0] obs, input logic [144:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_txn(input logic [3:0] off, input logic [7:0] len, input logic [11:0] nb);
      txn_valid  = 1'b1;
      txn_off    = off;
      txn_len    = len;
      txn_nbytes = nb;
   endtask

   task automatic set_data(input int n, input logic [15:0] s);
      data_valid = 1'b1;
      data       = pat(n);
      strb       = s;
   endtask

   task automatic clr();
      txn_valid  = 1'b0;
      data_valid = 1'b0;
   endtask

   initial begin
      // ---------------- reset values
      tick();
      tick();
      chk("rst_valid",      145'(w_if.axi_w_valid_o), 145'(0));
      chk("rst_last",       145'(w_if.w_last_o),      145'(0));
      chk("rst_done",       145'(done),               145'(0));
      chk("rst_busy",       145'(busy),               145'(0));
      chk("rst_txn_ready",  145'(txn_ready),          145'(1));
      chk("rst_data_ready", 145'(data_ready),         145'(1));
      rst_n = 1'b1;
      tick();

      // ---------------- single beat off=3 nbytes=5
      set_txn(4'd3, 8'd0, 12'd5);
      set_data(1, 16'hFFFF);
      user  = 1'b1;
      ready = 1'b1;
      tick();
      clr();
      user = 1'b0;
      chk("t1_valid", 145'(w_if.axi_w_valid_o), 145'(1));
      chk("t1_strb",  145'(w_if.w_strb_o),      145'(16'h00F8));
      chk("t1_last",  145'(w_if.w_last_o),      145'(1));
      chk("t1_data",  145'(w_if.w_data_o),      145'(pat(1)));
      chk("t1_user",  145'(w_if.w_user_o),      145'(1));
      tick();
      chk("t1_done",  145'(done),               145'(1));
      chk("t1_idle",  145'(w_if.axi_w_valid_o), 145'(0));
      chk("t1_busy",  145'(busy),               145'(0));
      tick();
      chk("t1_done_pulse", 145'(done), 145'(0));

      // ---------------- three beats off=4 nbytes=40, beat-2 mask 0x00FF
      ready = 1'b0;
      set_txn(4'd4, 8'd2, 12'd40);
      set_data(10, 16'hFFFF);
      tick();
      txn_valid = 1'b0;
      set_data(11, 16'h00FF);
      chk("t2_b0_strb", 145'(w_if.w_strb_o), 145'(16'hFFF0));
      chk("t2_b0_last", 145'(w_if.w_last_o), 145'(0));
      tick();
      set_data(12, 16'hFFFF);
      chk("t2_b0_hold", 145'(w_if.w_data_o), 145'(pat(10)));
      tick();
      clr();
      ready = 1'b1;
      chk("t2_b0_strb2", 145'(w_if.w_strb_o), 145'(16'hFFF0));
      tick();
      chk("t2_b1_strb", 145'(w_if.w_strb_o), 145'(16'h00FF));
      chk("t2_b1_last", 145'(w_if.w_last_o), 145'(0));
      chk("t2_b1_data", 145'(w_if.w_data_o), 145'(pat(11)));
      tick();
      chk("t2_b2_strb", 145'(w_if.w_strb_o), 145'(16'h0FFF));
      chk("t2_b2_last", 145'(w_if.w_last_o), 145'(1));
      tick();
      chk("t2_done",    145'(done),               145'(1));
      chk("t2_idle",    145'(w_if.axi_w_valid_o), 145'(0));

      // ---------------- three back-to-back len=1 bursts, no bubble
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) set_txn(4'd0, 8'd1, 12'd32);
         else txn_valid = 1'b0;
         set_data(20 + i, 16'hFFFF);
         tick();
      end
      clr();
      chk("t3_data_full", 145'(data_ready), 145'(0));
      chk("t3_txn_room",  145'(txn_ready),  145'(1));
      chk("t3_busy",      145'(busy),       145'(1));
      nxt   = 24;
      ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (data_ready && nxt < 26) set_data(nxt, 16'hFFFF);
         else data_valid = 1'b0;
         chk("t3_valid", 145'(w_if.axi_w_valid_o), 145'(1));
         chk("t3_last",  145'(w_if.w_last_o),      145'((cyc % 2) == 1));
         chk("t3_data",  145'(w_if.w_data_o),      145'(pat(20 + cyc)));
         chk("t3_strb",  145'(w_if.w_strb_o),      145'(16'hFFFF));
         acc = data_valid && data_ready;
         tick();
         if (acc) nxt++;
      end
      clr();
      ready = 1'b0;
      chk("t3_done", 145'(done), 145'(1));
      chk("t3_busy_end", 145'(busy), 145'(0));

      // ---------------- fill both FIFOs, then random backpressure
      for (int i = 0; i < 4; i++) begin
         set_txn(4'd0, 8'd0, 12'd16);
         set_data(30 + i, 16'hFFFF);
         tick();
      end
      clr();
      chk("t4_txn_full",  145'(txn_ready),  145'(0));
      chk("t4_data_full", 145'(data_ready), 145'(0));
      k = 0;
      have_prev = 1'b0;
      prev_pay = '0;
      for (int c = 0; c < 200 && k < 4; c++) begin
         if (have_prev)
            chk("t4_stable", {w_if.w_data_o, w_if.w_strb_o, w_if.w_last_o}, prev_pay);
         chk("t4_valid", 145'(w_if.axi_w_valid_o), 145'(1));
         chk("t4_data",  145'(w_if.w_data_o),      145'(pat(30 + k)));
         chk("t4_last",  145'(w_if.w_last_o),      145'(1));
         ready     = 1'($urandom_range(0, 1));
         prev_pay  = {w_if.w_data_o, w_if.w_strb_o, w_if.w_last_o};
         have_prev = !ready;
         hs        = ready;
         tick();
         if (hs) k++;
      end
      chk("t4_beats", 145'(k), 145'(4));
      ready = 1'b0;
      tick();

      // ---------------- end on bus boundary, mask vs no mask
      set_txn(4'd0, 8'd1, 12'd32);
      set_data(40, 16'hFFFF);
      tick();
      txn_valid = 1'b0;
      set_data(41, 16'h0000);
      tick();
      clr();
      chk("t5_b0_strb",    145'(w_if.w_strb_o),  145'(16'hFFFF));
      chk("t5_b0_strb_nm", 145'(w_if2.w_strb_o), 145'(16'hFFFF));
      ready = 1'b1;
      tick();
      chk("t5_b1_strb",    145'(w_if.w_strb_o),  145'(16'h0000));
      chk("t5_b1_strb_nm", 145'(w_if2.w_strb_o), 145'(16'hFFFF));
      chk("t5_b1_last",    145'(w_if.w_last_o),  145'(1));
      tick();
      ready = 1'b0;

      // ---------------- reset mid-burst, then fresh burst starts at beat 0
      set_txn(4'd0, 8'd3, 12'd64);
      set_data(50, 16'hFFFF);
      tick();
      txn_valid = 1'b0;
      set_data(51, 16'hFFFF);
      tick();
      set_data(52, 16'hFFFF);
      tick();
      set_data(53, 16'hFFFF);
      tick();
      clr();
      ready = 1'b1;
      tick();
      chk("t6_mid_data", 145'(w_if.w_data_o), 145'(pat(51)));
      rst_n = 1'b0;
      ready = 1'b0;
      #1;
      chk("t6_rst_valid",      145'(w_if.axi_w_valid_o), 145'(0));
      chk("t6_rst_busy",       145'(busy),               145'(0));
      chk("t6_rst_txn_ready",  145'(txn_ready),          145'(1));
      chk("t6_rst_data_ready", 145'(data_ready),         145'(1));
      tick();
      rst_n = 1'b1;
      tick();
      set_txn(4'd2, 8'd1, 12'd20);
      set_data(60, 16'hFFFF);
      ready = 1'b1;
      tick();
      txn_valid = 1'b0;
      set_data(61, 16'hFFFF);
      chk("t6_b0_strb", 145'(w_if.w_strb_o), 145'(16'hFFFC));
      chk("t6_b0_last", 145'(w_if.w_last_o), 145'(0));
      chk("t6_b0_data", 145'(w_if.w_data_o), 145'(pat(60)));
      tick();
      clr();
      chk("t6_b1_strb", 145'(w_if.w_strb_o), 145'(16'h003F));
      chk("t6_b1_last", 145'(w_if.w_last_o), 145'(1));
      tick();
      ready = 1'b0;
      chk("t6_done", 145'(done), 145'(1));
      chk("t6_busy", 145'(busy), 145'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
